// File: rtl/cpu_pkg.sv
// Shared CPU constants and the instruction-memory loader state encoding.
// Used by the loader and by instr_mem.
package cpu_pkg;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 16;
  localparam int IMEM_DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LEN,
    LD_HI,
    LD_LO,
    LD_CSUM,
    LD_DONE,
    LD_ERR
  } ld_state_t;

  // Modulo-256 running sum; a good image sums to zero including LEN and CSUM.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = loader side, slave = stream source / memory side.
interface imem_loader_if #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W
);

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [DATA_W-1:0] imem_wdata;

  modport master (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_waddr, imem_wdata
  );

endinterface

// File: rtl/imem_loader.sv
// Loads a LEN/data/CSUM byte stream into instruction memory, high byte first,
// and holds the CPU until a load finishes with a good checksum.
module imem_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  imem_loader_if.master     bus,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold
);

  // One extra bit so a full 256-word image never wraps the word index.
  localparam int                IDX_W = ADDR_W + 1;
  localparam logic [IDX_W-1:0]  FULL  = IDX_W'(2 ** ADDR_W);

  ld_state_t         st;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  nwords;
  logic [IDX_W-1:0]  idx_nx;
  logic [7:0]        sum;
  logic [7:0]        sum_nx;
  logic [7:0]        hi;
  logic              xfer;

  // in_ready is registered, so xfer has no combinational path from in_valid to in_ready.
  assign xfer   = bus.in_valid & bus.in_ready;
  assign idx_nx = idx + IDX_W'(1);
  assign sum_nx = csum_add(sum, bus.in_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st             <= LD_IDLE;
      bus.in_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_waddr <= '0;
      bus.imem_wdata <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      cpu_hold       <= 1'b0;
      idx            <= '0;
      nwords         <= '0;
      sum            <= '0;
      hi             <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      if (abort) begin
        st           <= LD_IDLE;
        bus.in_ready <= 1'b0;
        busy         <= 1'b0;
        done         <= 1'b0;
        error        <= 1'b0;
        cpu_hold     <= 1'b0;
      end else begin
        case (st)
          LD_IDLE, LD_DONE, LD_ERR: begin
            if (start) begin
              st           <= LD_LEN;
              bus.in_ready <= 1'b1;
              busy         <= 1'b1;
              cpu_hold     <= 1'b1;
              done         <= 1'b0;
              error        <= 1'b0;
              idx          <= '0;
              sum          <= '0;
            end
          end
          LD_LEN: begin
            if (xfer) begin
              nwords <= (bus.in_data == 8'd0) ? FULL : IDX_W'(bus.in_data);
              sum    <= sum_nx;
              st     <= LD_HI;
            end
          end
          LD_HI: begin
            if (xfer) begin
              hi  <= bus.in_data;
              sum <= sum_nx;
              st  <= LD_LO;
            end
          end
          LD_LO: begin
            if (xfer) begin
              bus.imem_wdata <= DATA_W'({hi, bus.in_data});
              bus.imem_waddr <= idx[ADDR_W-1:0];
              bus.imem_we    <= 1'b1;
              idx            <= idx_nx;
              sum            <= sum_nx;
              st             <= (idx_nx == nwords) ? LD_CSUM : LD_HI;
            end
          end
          LD_CSUM: begin
            if (xfer) begin
              bus.in_ready <= 1'b0;
              busy         <= 1'b0;
              sum          <= sum_nx;
              if (sum_nx == 8'd0) begin
                st       <= LD_DONE;
                done     <= 1'b1;
                cpu_hold <= 1'b0;
              end else begin
                st    <= LD_ERR;
                error <= 1'b1;
              end
            end
          end
          default: begin
            st           <= LD_IDLE;
            bus.in_ready <= 1'b0;
            busy         <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: streams are checked against a reference
// built directly from the LEN/data/CSUM image format.
module tb_imem_loader;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic abort;
  logic busy;
  logic done;
  logic error;
  logic cpu_hold;

  imem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc ();

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .bus      (ifc),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .cpu_hold (cpu_hold)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]               stim[$];
  logic [ADDR_W+DATA_W-1:0] wq[$];

  always @(negedge clk) begin
    if (ifc.imem_we) wq.push_back({ifc.imem_waddr, ifc.imem_wdata});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Image of n words; data random or {i, ~i}; CSUM correct unless good=0.
  task automatic build(input int n, input bit good, input bit rnd);
    logic [7:0] s;
    logic [7:0] b;
    stim.delete();
    stim.push_back(n[7:0]);
    for (int i = 0; i < n; i++) begin
      b = i[7:0];
      stim.push_back(rnd ? 8'($urandom) : b);
      stim.push_back(rnd ? 8'($urandom) : ~b);
    end
    s = 8'd0;
    foreach (stim[k]) s = s + stim[k];
    stim.push_back(good ? 8'(-s) : 8'(8'd1 - s));
  endtask

  task automatic set_t1(input bit good);
    stim = '{8'h02, 8'h50, 8'h05, 8'h51, 8'h0A, 8'h4E};
    if (!good) stim[5] = 8'h4F;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents stim[0..upto-1]; start is also pulsed together with byte start_at.
  task automatic send(input int upto, input bit gaps, input int start_at);
    int w;
    for (int k = 0; k < upto; k++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        ifc.in_valid = 1'b0;
        @(negedge clk);
      end
      ifc.in_data  = stim[k];
      ifc.in_valid = 1'b1;
      if (k == start_at) start = 1'b1;
      w = 0;
      while (!ifc.in_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (w >= 50) begin
        chk("ready_timeout", 32'd0, 32'd1);
        ifc.in_valid = 1'b0;
        start = 1'b0;
        return;
      end
      @(negedge clk);
      start = 1'b0;
    end
    ifc.in_valid = 1'b0;
  endtask

  task automatic check_result(input string tag);
    int         n;
    logic [7:0] s;
    bit         ok;
    logic [ADDR_W-1:0] a;
    n = (stim[0] == 8'd0) ? IMEM_DEPTH : int'(stim[0]);
    s = 8'd0;
    foreach (stim[k]) s = s + stim[k];
    ok = (s == 8'd0);
    chk($sformatf("%s_nwrites", tag), wq.size(), n);
    for (int i = 0; i < n && i < wq.size(); i++) begin
      a = i[ADDR_W-1:0];
      chk($sformatf("%s_w%0d", tag, i), wq[i], {a, stim[1+2*i], stim[2+2*i]});
    end
    chk($sformatf("%s_done", tag), done, ok);
    chk($sformatf("%s_error", tag), error, !ok);
    chk($sformatf("%s_hold", tag), cpu_hold, !ok);
    chk($sformatf("%s_busy", tag), busy, 1'b0);
    chk($sformatf("%s_ready", tag), ifc.in_ready, 1'b0);
  endtask

  task automatic run_load(input string tag, input bit gaps, input int start_at);
    wq.delete();
    do_start();
    chk($sformatf("%s_hold_on", tag), cpu_hold, 1'b1);
    chk($sformatf("%s_busy_on", tag), busy, 1'b1);
    send(stim.size(), gaps, start_at);
    repeat (2) @(negedge clk);
    check_result(tag);
  endtask

  task automatic check_idle(input string tag);
    chk($sformatf("%s_ready", tag), ifc.in_ready, 1'b0);
    chk($sformatf("%s_we", tag), ifc.imem_we, 1'b0);
    chk($sformatf("%s_busy", tag), busy, 1'b0);
    chk($sformatf("%s_done", tag), done, 1'b0);
    chk($sformatf("%s_error", tag), error, 1'b0);
    chk($sformatf("%s_hold", tag), cpu_hold, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_data = 8'd0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    chk("reset_waddr", ifc.imem_waddr, 0);
    chk("reset_wdata", ifc.imem_wdata, 0);
    rst = 1'b0;
    @(negedge clk);

    set_t1(1'b1);
    run_load("t1", 1'b0, -1);
    set_t1(1'b0);
    run_load("t2", 1'b0, -1);
    build(256, 1'b1, 1'b0);
    stim[0] = 8'h00;
    run_load("t3", 1'b0, -1);
    for (int r = 0; r < 3; r++) begin
      set_t1(1'b1);
      run_load($sformatf("t4_%0d", r), 1'b1, -1);
    end

    set_t1(1'b1);
    wq.delete();
    do_start();
    send(3, 1'b0, -1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_nwrites", wq.size(), 1);
    if (wq.size() > 0) chk("t5_w0", wq[0], {8'h00, 16'h5005});
    check_idle("t5");

    set_t1(1'b1);
    wq.delete();
    do_start();
    send(3, 1'b0, -1);
    rst = 1'b1;
    #1;
    check_idle("t6_rst");
    chk("t6_rst_waddr", ifc.imem_waddr, 0);
    chk("t6_rst_wdata", ifc.imem_wdata, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_load("t6", 1'b0, 2);

    for (int r = 0; r < 6; r++) begin
      build($urandom_range(1, 8), $urandom_range(0, 1) == 1, 1'b1);
      run_load($sformatf("rnd%0d", r), 1'b1, $urandom_range(1, 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
